button_debouncer: RTL and testbench

Cleans one raw, asynchronous push-button input for the alarm-clock control path. It synchronises the input into the `clk` domain and filters contact bounce with a stability counter. It drives a clean, glitch-free level `btn_db` straight into the rising-edge pulse detector that follows it. Optional auto-repeat drops `btn_db` low for one cycle at a fixed rate while the button is held, so the downstream detector emits repeated increment pulses for time/alarm setting.

---
 rtl/button_debouncer.sv | 156 +++++++++++++++
 tb/tb_button_debouncer.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/button_debouncer.sv
// button_debouncer: two-flop synchroniser plus stability-counter FSM that turns a bouncy push button into a clean level.
// Define DEBOUNCE_REPEAT_EN to add auto-repeat: one-cycle low gaps on btn_db while the button is held.
module button_debouncer #(
    parameter int unsigned STABLE_CYCLES = 500000,
    parameter int unsigned REPEAT_DELAY  = 25000000,
    parameter int unsigned REPEAT_PERIOD = 12500000,
    parameter int unsigned CNT_W         = 25
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    output logic btn_db,
    output logic bouncing
);

    // state        | meaning
    // IDLE         | released, btn_db=0
    // WAIT_PRESS   | high seen, qualifying press, btn_db=0
    // PRESSED      | accepted press, btn_db=1
    // WAIT_RELEASE | low seen, qualifying release, btn_db=1
    // GAP          | one-cycle repeat gap, btn_db=0 (auto-repeat build only)
    typedef enum logic [2:0] {
        IDLE         = 3'd0,
        WAIT_PRESS   = 3'd1,
        PRESSED      = 3'd2,
        WAIT_RELEASE = 3'd3,
        GAP          = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    // Reject parameter sets whose terminal values do not fit the counters.
    if (64'(STABLE_CYCLES) < 64'd2 ||
        64'(STABLE_CYCLES) > ((64'd1 << CNT_W) - 64'd1) ||
        64'(REPEAT_DELAY)  < 64'd1 ||
        64'(REPEAT_DELAY)  > (64'd1 << CNT_W) ||
        64'(REPEAT_PERIOD) < 64'd1 ||
        64'(REPEAT_PERIOD) > (64'd1 << CNT_W)) begin : g_bad_params
        $error("button_debouncer: parameter out of range for CNT_W");
    end

    logic             s1;
    logic             s2;
    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= btn_in;
            s2 <= s1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

`ifdef DEBOUNCE_REPEAT_EN
    localparam logic [CNT_W-1:0] RPT_DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RPT_PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);

    logic [CNT_W-1:0] rpt;
    logic [CNT_W-1:0] rpt_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rpt <= '0;
        end else begin
            rpt <= rpt_nxt;
        end
    end
`endif

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
`ifdef DEBOUNCE_REPEAT_EN
        rpt_nxt   = rpt;
`endif
        unique case (state)
            IDLE: begin
                if (s2) begin
                    state_nxt = WAIT_PRESS;
                    cnt_nxt   = CNT_ONE;
                end
            end
            WAIT_PRESS: begin
                if (!s2) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if (cnt == STABLE_LAST) begin
                    state_nxt = PRESSED;
                    cnt_nxt   = '0;
`ifdef DEBOUNCE_REPEAT_EN
                    rpt_nxt   = RPT_DELAY_LAST;
`endif
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            PRESSED: begin
                if (!s2) begin
                    state_nxt = WAIT_RELEASE;
                    cnt_nxt   = CNT_ONE;
                end
`ifdef DEBOUNCE_REPEAT_EN
                else if (rpt == '0) begin
                    state_nxt = GAP;
                end else begin
                    rpt_nxt = rpt - CNT_ONE;
                end
`endif
            end
            WAIT_RELEASE: begin
                // Returning to PRESSED keeps the repeat schedule running across a release glitch.
                if (s2) begin
                    state_nxt = PRESSED;
                    cnt_nxt   = '0;
                end else if (cnt == STABLE_LAST) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
`ifdef DEBOUNCE_REPEAT_EN
            GAP: begin
                state_nxt = PRESSED;
                rpt_nxt   = RPT_PERIOD_LAST;
            end
`endif
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_comb begin
        btn_db   = (state == PRESSED) || (state == WAIT_RELEASE);
        bouncing = (state == WAIT_PRESS) || (state == WAIT_RELEASE);
    end

endmodule

// File: tb/tb_button_debouncer.sv
// Bench for button_debouncer: a cycle model of the debounce rules feeds a scoreboard checked every cycle,
// plus directed latency / pulse-count checks. Auto-repeat expectations follow DEBOUNCE_REPEAT_EN.
module tb_button_debouncer;

    localparam int STABLE_CYCLES = 4;
    localparam int REPEAT_DELAY  = 10;
    localparam int REPEAT_PERIOD = 5;
    localparam int CNT_W         = 8;

    logic clk    = 1'b0;
    logic rst    = 1'b1;
    logic btn_in = 1'b0;
    logic btn_db;
    logic bouncing;

    always #5 clk = ~clk;

    button_debouncer #(
        .STABLE_CYCLES (STABLE_CYCLES),
        .REPEAT_DELAY  (REPEAT_DELAY),
        .REPEAT_PERIOD (REPEAT_PERIOD),
        .CNT_W         (CNT_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .btn_in   (btn_in),
        .btn_db   (btn_db),
        .bouncing (bouncing)
    );

    typedef struct packed {
        logic db;
        logic bnc;
    } exp_t;

    exp_t sb_q[$];

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: run length of samples disagreeing with the accepted level.
    logic m_s1, m_s2, m_db, m_gap;
    int   m_run, m_t, m_per;

    int   edge_n;
    logic prev_db;
    int   rise_n, fall_n, last_rise, last_fall, first_fall;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at t=%0t: got %0d expected %0d", tag, $time, got, exp);
        end
    endtask

    task automatic model_reset();
        m_s1  = 1'b0;
        m_s2  = 1'b0;
        m_db  = 1'b0;
        m_gap = 1'b0;
        m_run = 0;
        m_t   = 0;
        m_per = REPEAT_DELAY;
    endtask

    task automatic model_edge();
        if (rst) begin
            model_reset();
        end else begin
            if (m_gap) begin
                m_gap = 1'b0;
                m_t   = 0;
                m_per = REPEAT_PERIOD;
            end else if (m_s2 != m_db) begin
                m_run++;
                if (m_run == STABLE_CYCLES) begin
                    m_db  = ~m_db;
                    m_run = 0;
                    m_t   = 0;
                    m_per = REPEAT_DELAY;
                end
            end else if (m_run != 0) begin
                m_run = 0;
            end else if (m_db) begin
`ifdef DEBOUNCE_REPEAT_EN
                m_t++;
                if (m_t == m_per) m_gap = 1'b1;
`endif
            end
            m_s2 = m_s1;
            m_s1 = btn_in;
        end
    endtask

    task automatic clear_stats();
        edge_n     = -1;
        rise_n     = 0;
        fall_n     = 0;
        last_rise  = -1;
        last_fall  = -1;
        first_fall = -1;
    endtask

    task automatic step(input logic b);
        exp_t e;
        btn_in = b;
        @(posedge clk);
        edge_n++;
        model_edge();
        e.db  = m_db & ~m_gap;
        e.bnc = (m_run != 0);
        sb_q.push_back(e);
        @(negedge clk);
        if (sb_q.size() == 0) begin
            chk("sb_underflow", 32'd0, 32'd1);
        end else begin
            e = sb_q.pop_front();
            chk("btn_db", btn_db, e.db);
            chk("bouncing", bouncing, e.bnc);
        end
        if (btn_db && !prev_db) begin
            rise_n++;
            last_rise = edge_n;
        end
        if (!btn_db && prev_db) begin
            fall_n++;
            last_fall = edge_n;
            if (first_fall < 0) first_fall = edge_n;
        end
        prev_db = btn_db;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("rst_btn_db", btn_db, 1'b0);
        chk("rst_bouncing", bouncing, 1'b0);
        step(1'b0);
        step(1'b0);
        rst     = 1'b0;
        prev_db = 1'b0;
    endtask

    initial begin
        model_reset();
        clear_stats();
        prev_db = 1'b0;
        @(negedge clk);

        // Clean press then clean release.
        do_reset();
        clear_stats();
        repeat (10) step(1'b1);
        chk("press_rise_edge", last_rise, 5);
        chk("press_rise_count", rise_n, 1);
        repeat (10) step(1'b0);
        chk("release_fall_edge", last_fall, 15);

        // Press bouncing every cycle, then steady.
        do_reset();
        clear_stats();
        for (int i = 0; i < 8; i++) step((i % 2) == 0);
        repeat (10) step(1'b1);
        chk("bounce_rise_edge", last_rise, 13);
        chk("bounce_rise_count", rise_n, 1);

        // Short release glitch must not drop btn_db; a longer release does.
        do_reset();
        clear_stats();
        repeat (7) step(1'b1);
        repeat (3) step(1'b0);
        repeat (5) step(1'b1);
        chk("glitch_no_fall", fall_n, 0);
        repeat (10) step(1'b0);
        chk("long_release_fall_edge", last_fall, 20);
        chk("long_release_fall_count", fall_n, 1);

        // Reset while qualifying a release with the button still held.
        do_reset();
        clear_stats();
        repeat (8) step(1'b1);
        step(1'b0);
        step(1'b1);
        step(1'b1);
        chk("pre_rst_bouncing", bouncing, 1'b1);
        chk("pre_rst_btn_db", btn_db, 1'b1);
        btn_in = 1'b1;
        rst    = 1'b1;
        #1;
        chk("mid_rst_btn_db", btn_db, 1'b0);
        chk("mid_rst_bouncing", bouncing, 1'b0);
        step(1'b1);
        step(1'b1);
        rst     = 1'b0;
        prev_db = 1'b0;
        clear_stats();
        repeat (8) step(1'b1);
        chk("post_rst_rise_edge", last_rise, 5);
        chk("post_rst_rise_count", rise_n, 1);

        // Long hold: auto-repeat gaps or a single steady level.
        do_reset();
        clear_stats();
        repeat (40) step(1'b1);
        repeat (10) step(1'b0);
`ifdef DEBOUNCE_REPEAT_EN
        chk("hold_rise_count", rise_n, 6);
        chk("hold_fall_count", fall_n, 6);
        chk("hold_first_gap_edge", first_fall, 15);
`else
        chk("hold_rise_count", rise_n, 1);
        chk("hold_fall_count", fall_n, 1);
        chk("hold_first_fall_edge", first_fall, 45);
`endif
        chk("hold_release_fall_edge", last_fall, 45);

        chk("sb_drain", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
